vedic_mul8_sequencer: RTL and testbench

//  - Computes an unsigned 8x8 -> 16-bit product by time-sharing ONE vedic_4x4 multiplier instance over four nibble steps.
//  - Accumulates the shifted partial products into a 16-bit register.
//  - Valid/ready handshake on both input and output sides.
//  - Sits between a requesting datapath (or the tt_um top-level wrapper) and the 4x4 multiplier; it is the only user of that multiplier.

---
 rtl/vedic_mul8_sequencer.sv | 149 ++++++++++++++
 tb/tb_vedic_mul8_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul8_sequencer.sv
// Unsigned 8x8 -> 16-bit multiplier that reuses one vedic 4x4 core over four nibble steps.
// Latency: 4 edges from the accept edge to out_valid (5 with MUL_REG=1; 0 extra edges for zero operands under VSEQ_ZERO_SKIP_EN).
// Backpressure: in_ready is low from accept until the product is taken; p and out_valid hold until out_ready.
// Optional feature macro: VSEQ_ZERO_SKIP_EN (zero operand jumps straight to DONE with p=0).

// 4x4 vedic multiplier: four 2x2 crosswise blocks summed at their nibble weights.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // 2x2 vertical-and-crosswise product
    function automatic logic [3:0] v2x2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, c, t3;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        c  = t1 & t2;
        t3 = x[1] & y[1];
        return {t3 & c, t3 ^ c, t1 ^ t2, x[0] & y[0]};
    endfunction

    logic [3:0] q0, q1, q2, q3;

    // Combine the four 2x2 partial products at their bit weights
    always_comb begin
        q0 = v2x2(a[1:0], b[1:0]);
        q1 = v2x2(a[3:2], b[1:0]);
        q2 = v2x2(a[1:0], b[3:2]);
        q3 = v2x2(a[3:2], b[3:2]);
        p  = {4'h0, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'h0};
    end
endmodule

// Sequencer: steps the shared 4x4 core over (aL,bL),(aH,bL),(aL,bH),(aH,bH) and accumulates.
// Latency: accept edge + 4 MUL edges (+1 FLUSH edge when MUL_REG=1) before out_valid.
// Backpressure: single operand in flight; DONE holds until out_ready, in_valid ignored until IDLE.
module vedic_mul8_sequencer #(
    parameter int MUL_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, FLUSH, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [15:0] acc;
    logic [7:0]  op_a, op_b;
    logic [7:0]  prod, prod_q;
    logic [1:0]  nibs, nibs_q;
    logic [3:0]  nib_a, nib_b;
    logic [15:0] addend;
    logic        accept, skip;

    // Place an 8-bit partial product at a nibble offset (0, 1 or 2 nibbles)
    function automatic logic [15:0] place(input logic [7:0] v, input logic [1:0] n);
        return {8'h00, v} << {n, 2'b00};
    endfunction

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign nib_a  = step[0] ? op_a[7:4] : op_a[3:0];
    assign nib_b  = step[1] ? op_b[7:4] : op_b[3:0];
    assign nibs   = {1'b0, step[0]} + {1'b0, step[1]};
    assign accept = in_valid && (state == IDLE);

`ifdef VSEQ_ZERO_SKIP_EN
    assign skip = (a == 8'h00) || (b == 8'h00);
`else
    assign skip = 1'b0;
`endif

    vedic_4x4 u_mul (
        .a (nib_a),
        .b (nib_b),
        .p (prod)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = skip ? DONE : MUL;
            MUL:     if (step == 2'd3) state_nxt = (MUL_REG != 0) ? FLUSH : DONE;
            FLUSH:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; p mirrors the accumulator
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        p         = acc;
    end

    // Addend for this edge: live product, or the previous step's registered product
    always_comb begin
        addend = 16'h0000;
        if (MUL_REG != 0) begin
            if (state == FLUSH || (state == MUL && step != 2'd0))
                addend = place(prod_q, nibs_q);
        end else begin
            if (state == MUL)
                addend = place(prod, nibs);
        end
    end

    // Operand capture, accumulation and step counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= 8'h00;
            op_b   <= 8'h00;
            acc    <= 16'h0000;
            step   <= 2'd0;
            prod_q <= 8'h00;
            nibs_q <= 2'd0;
        end else if (accept) begin
            op_a <= a;
            op_b <= b;
            acc  <= 16'h0000;
            step <= 2'd0;
        end else if (state == MUL || state == FLUSH) begin
            acc <= acc + addend;
            if (state == MUL) begin
                step   <= step + 2'd1;
                prod_q <= prod;
                nibs_q <= nibs;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mul8_sequencer.sv
// Directed checks of vedic_mul8_sequencer: MUL_REG=0 instance for handshake/reset cases,
// MUL_REG=1 instance for a corner plus random operand sweep under random out_ready.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_vedic_mul8_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv0 = 1'b0, or0 = 1'b0, ir0, ov0, busy0;
    logic [7:0]  a0 = 8'h00, b0 = 8'h00;
    logic [15:0] p0;

    logic        iv1 = 1'b0, or1 = 1'b0, ir1, ov1, busy1;
    logic [7:0]  a1 = 8'h00, b1 = 8'h00;
    logic [15:0] p1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vedic_mul8_sequencer #(.MUL_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(or0), .p(p0), .busy(busy0)
    );

    vedic_mul8_sequencer #(.MUL_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand pair to dut0 for exactly one edge (dut0 must be IDLE)
    task automatic accept0(input logic [7:0] x, input logic [7:0] y);
        iv0 = 1'b1; a0 = x; b0 = y;
        tick();
        iv0 = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; in_ready must stay low meanwhile
    task automatic wait_ov0(input string tag, output int n);
        n = 0;
        while (!ov0 && n < 12) begin
            chk({tag, "_in_ready_low"}, ir0, 1'b0);
            tick();
            n++;
        end
    endtask

    int          lat;
    int          exp_lat;
    int          guard;
    logic        hs;
    logic [7:0]  sa, sb;
    logic [15:0] sp;
    logic [7:0]  ca [6];
    logic [7:0]  cb [6];

    initial begin
        ca = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h80, 8'h0F};
        cb = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'hF0};

        // Reset state
        tick(); tick();
        chk("rst_out_valid", ov0, 1'b0);
        chk("rst_p", p0, 16'h0000);
        chk("rst_busy", busy0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", ir0, 1'b1);
        chk("rst_out_valid_after", ov0, 1'b0);

        // 0xFF*0xFF with out_ready high: 4 edges, 0xFE01
        or0 = 1'b1;
        accept0(8'hFF, 8'hFF);
        wait_ov0("ff", lat);
        chk("ff_latency", lat, 4);
        chk("ff_p", p0, 16'hFE01);
        tick();
        chk("ff_back_idle", ir0, 1'b1);
        chk("ff_valid_drop", ov0, 1'b0);

        // 0x12*0x34 with out_ready low for 3 cycles: hold 0x03A8
        or0 = 1'b0;
        accept0(8'h12, 8'h34);
        wait_ov0("hold", lat);
        chk("hold_latency", lat, 4);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", ov0, 1'b1);
            chk("hold_p", p0, 16'h03A8);
            tick();
        end
        chk("hold_valid_last", ov0, 1'b1);
        or0 = 1'b1;
        tick();
        chk("hold_idle", ir0, 1'b1);
        chk("hold_valid_drop", ov0, 1'b0);

        // 0x0F*0xF0, new pair held valid during MUL must wait for IDLE
        accept0(8'h0F, 8'hF0);
        iv0 = 1'b1; a0 = 8'hAA; b0 = 8'h55;
        wait_ov0("busy", lat);
        chk("busy_latency", lat, 4);
        chk("busy_p", p0, 16'h0E10);
        tick();
        chk("busy_done_to_idle", ir0, 1'b1);
        chk("busy_second_not_yet", ov0, 1'b0);
        tick();
        iv0 = 1'b0;
        chk("second_accepted", busy0, 1'b1);
        wait_ov0("second", lat);
        chk("second_latency", lat, 4);
        chk("second_p", p0, 16'h3872);
        tick();

        // Reset during step 2 of 0x9C*0x7B discards the product
        accept0(8'h9C, 8'h7B);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", ov0, 1'b0);
        chk("midrst_p", p0, 16'h0000);
        chk("midrst_idle", ir0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_stale", ov0, 1'b0);
            tick();
        end
        accept0(8'h03, 8'h05);
        wait_ov0("after_rst", lat);
        chk("after_rst_latency", lat, 4);
        chk("after_rst_p", p0, 16'h000F);
        tick();

        // Zero operand: with skip, out_valid is up right after the accepting edge
`ifdef VSEQ_ZERO_SKIP_EN
        exp_lat = 0;
`else
        exp_lat = 4;
`endif
        accept0(8'h00, 8'hAB);
        lat = 0;
        while (!ov0 && lat < 12) begin
            tick();
            lat++;
        end
        chk("zero_latency", lat, exp_lat);
        chk("zero_p", p0, 16'h0000);
        tick();
        chk("zero_idle", ir0, 1'b1);

        // MUL_REG=1 sweep: corners then random pairs, random out_ready
        for (int i = 0; i < 400; i++) begin
            if (i < 6) begin
                sa = ca[i]; sb = cb[i];
            end else begin
                sa = 8'($urandom_range(0, 255));
                sb = 8'($urandom_range(0, 255));
            end
            sp = 16'(sa) * 16'(sb);
`ifdef VSEQ_ZERO_SKIP_EN
            exp_lat = (sa == 8'h00 || sb == 8'h00) ? 0 : 5;
`else
            exp_lat = 5;
`endif
            or1 = 1'b0;
            chk("sweep_in_ready", ir1, 1'b1);
            iv1 = 1'b1; a1 = sa; b1 = sb;
            tick();
            iv1 = 1'b0; a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
            lat = 0;
            while (!ov1 && lat < 12) begin
                tick();
                lat++;
            end
            chk("sweep_latency", lat, exp_lat);
            guard = 0;
            hs = 1'b0;
            while (!hs && guard < 20) begin
                or1 = 1'($urandom_range(0, 1));
                chk("sweep_p", p1, sp);
                chk("sweep_valid_held", ov1, 1'b1);
                hs = ov1 && or1;
                tick();
                guard++;
            end
            chk("sweep_handshake", hs, 1'b1);
            chk("sweep_no_dup", ov1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
